// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to round key 10, then runs
// ten inverse rounds while walking the key schedule backwards one round per cycle.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
    typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    state_t        r_state;
    state_t        w_next;
    logic [127:0]  r_key;
    logic [127:0]  r_st;
    logic [127:0]  r_data_out;
    logic [3:0]    r_cnt;
    logic [7:0]    w_rcon;
    logic [127:0]  w_fwd_key;
    logic [127:0]  w_prev_key;
    logic [127:0]  w_ark;
    logic [127:0]  w_round;

    // Table byte 0 sits in the MSBs, so entry x starts at bit (255-x)*8 = {~x,3'b0}.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] m);
        logic [7:0] x2, x4, x8, acc;
        x2  = xtime(x);
        x4  = xtime(x2);
        x8  = xtime(x4);
        acc = 8'h00;
        if (m[0]) acc = acc ^ x;
        if (m[1]) acc = acc ^ x2;
        if (m[2]) acc = acc ^ x4;
        if (m[3]) acc = acc ^ x8;
        return acc;
    endfunction

    function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rc);
        return {sub_byte(w[23:16]) ^ rc, sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ key_f(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one schedule step: the previous last word is recovered first, then feeds f().
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ key_f(p3, rc);
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sub_byte(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    always_comb begin
        w_rcon = 8'h00;
        case (r_cnt)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // The same rcon index serves both directions: KEXP counts up, ROUND counts down.
    always_comb begin
        w_fwd_key  = key_fwd(r_key, w_rcon);
        w_prev_key = key_inv(r_key, w_rcon);
        w_ark      = inv_shift_sub(r_st) ^ w_prev_key;
        w_round    = (r_cnt == 4'd0) ? w_ark : inv_mix(w_ark);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = KEXP;
            KEXP:    if (r_cnt == 4'd9) w_next = INIT;
            INIT:    w_next = ROUND;
            ROUND:   if (r_cnt == 4'd0) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
        data_out  = r_data_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key      <= '0;
            r_st       <= '0;
            r_data_out <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_st  <= data_in;
                        r_key <= key;
                        r_cnt <= 4'd0;
                    end
                end
                KEXP: begin
                    r_key <= w_fwd_key;
                    r_cnt <= r_cnt + 4'd1;
                end
                INIT: begin
                    r_st  <= r_st ^ r_key;
                    r_cnt <= 4'd9;
                end
                ROUND: begin
                    r_key <= w_prev_key;
                    r_st  <= w_round;
                    if (r_cnt == 4'd0) begin
                        r_data_out <= w_round;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors, latency, backpressure,
// busy-time input, mid-operation reset and back-to-back issue.
module tb_aes_decrypt_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] data_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    aes_decrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Offers one vector from a falling edge; returns on the falling edge after the handshake.
    task automatic start_op(input logic [127:0] ct, input logic [127:0] k, output int hs_cyc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        data_in  = ct;
        key      = k;
        @(posedge clk);
        @(negedge clk);
        hs_cyc   = cyc;
        in_valid = 1'b0;
    endtask

    // n = index of the rising edge (after the handshake) at which out_valid is first seen high.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_c1();
        int hs, n;
        start_op(C1_CT, C1_KEY, hs);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL c1_busy got=%b want=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL c1_in_ready_busy got=%b want=0", in_ready); end
        wait_out(n);
        total++; if (n !== 22) begin bad++; $display("FAIL c1_latency got=%0d want=22", n); end
        total++; if (data_out !== C1_PT) begin bad++; $display("FAIL c1_data got=%h want=%h", data_out, C1_PT); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL c1_in_ready_done got=%b want=0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL c1_release got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL c1_idle_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure();
        int hs, n;
        start_op(B_CT, B_KEY, hs);
        wait_out(n);
        total++; if (n !== 22) begin bad++; $display("FAIL b_latency got=%0d want=22", n); end
        for (int i = 0; i < 7; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cycle=%0d got=%b want=1", i, out_valid); end
            total++; if (data_out !== B_PT) begin bad++; $display("FAIL bp_data cycle=%0d got=%h want=%h", i, data_out, B_PT); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_busy_ignore();
        int hs, n;
        start_op(C1_CT, C1_KEY, hs);
        n = 1;
        while (!out_valid && n < 40) begin
            in_valid = (n == 3 || n == 11 || n == 16);
            data_in  = B_CT;
            key      = B_KEY;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        total++; if (n !== 22) begin bad++; $display("FAIL busy_latency got=%0d want=22", n); end
        total++; if (data_out !== C1_PT) begin bad++; $display("FAIL busy_data got=%h want=%h", data_out, C1_PT); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL busy_extra cycle=%0d got=%b%b want=00", i, out_valid, busy); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_round();
        int hs, n;
        start_op(B_CT, B_KEY, hs);
        repeat (14) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        total++; if (data_out !== 128'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", data_out); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        start_op(C1_CT, C1_KEY, hs);
        wait_out(n);
        total++; if (n !== 22) begin bad++; $display("FAIL mid_c1_latency got=%0d want=22", n); end
        total++; if (data_out !== C1_PT) begin bad++; $display("FAIL mid_c1_data got=%h want=%h", data_out, C1_PT); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t1, t2, n, guard;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = C1_CT;
        key      = C1_KEY;
        guard = 0;
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        t1      = cyc;
        data_in = B_CT;
        key     = B_KEY;
        wait_out(n);
        total++; if (n !== 22) begin bad++; $display("FAIL b2b_lat1 got=%0d want=22", n); end
        total++; if (data_out !== C1_PT) begin bad++; $display("FAIL b2b_data1 got=%h want=%h", data_out, C1_PT); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        t2       = cyc;
        in_valid = 1'b0;
        total++; if (t2 - t1 !== 23) begin bad++; $display("FAIL b2b_interval got=%0d want=23", t2 - t1); end
        wait_out(n);
        total++; if (n !== 22) begin bad++; $display("FAIL b2b_lat2 got=%0d want=22", n); end
        total++; if (data_out !== B_PT) begin bad++; $display("FAIL b2b_data2 got=%h want=%h", data_out, B_PT); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_release got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_c1();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_round();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
